fib_bcd_converter: RTL and testbench

- Downstream stage of the fibonacci core. Consumes its binary result (fib, valid) and converts it to packed BCD for display/print logic.
- Iterative double-dabble converter: one shift per clock.
- Captures on the rising edge of the core's valid, because the core holds valid as a level.
- Presents the result with a valid/ready handshake.

---
 rtl/fib_bcd_converter_pkg.sv | 12 +
 rtl/fib_bcd_converter_bcd_digit_adj.sv | 15 +
 rtl/fib_bcd_converter.sv | 124 ++++++++++++
 tb/tb_fib_bcd_converter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fib_bcd_converter_pkg.sv
// Shared definitions for the fibonacci BCD conversion stage:
// FSM state encodings and the default widths used by both core and converter.
package fib_bcd_converter_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam int DEF_IN_SIZE = 32;
   localparam int DEF_DIGITS  = 10;

endpackage

// File: rtl/fib_bcd_converter_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
   input  logic [3:0] d_i,
   output logic [3:0] d_o
);

   always_comb begin
      d_o = d_i;
      if (d_i >= 4'd5) begin
         d_o = d_i + 4'd3;
      end
   end

endmodule

// File: rtl/fib_bcd_converter.sv
// Iterative binary-to-packed-BCD converter (one double-dabble shift per clock),
// captured on the rising edge of the upstream level valid, output via valid/ready.
module fib_bcd_converter
   import fib_bcd_converter_pkg::*;
#(
   parameter int in_size = DEF_IN_SIZE,
   parameter int digits  = DEF_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [in_size-1:0]    in_data,
   output logic                  busy,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*digits-1:0]   bcd,
   output logic                  dropped
);

   localparam int BW = 4 * digits;
   localparam int CW = $clog2(in_size + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(in_size - 1);

   logic [1:0]          state_q, state_d;
   logic                in_valid_dly_q;
   logic [in_size-1:0]  bin_q, bin_d;
   logic [BW-1:0]       bcd_q, bcd_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                out_valid_q, out_valid_d;
   logic                busy_q, busy_d;
   logic                dropped_q, dropped_d;

   logic                rise;
   logic                capture;
   logic [BW-1:0]       bcd_adj;
   logic [BW+in_size-1:0] shifted;

   for (genvar g = 0; g < digits; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .d_i (bcd_q[4*g +: 4]),
         .d_o (bcd_adj[4*g +: 4])
      );
   end

   assign shifted = {bcd_adj, bin_q} << 1;
   assign rise    = in_valid & ~in_valid_dly_q;
   // A completing transfer and a new edge on the same clock start the next conversion directly.
   assign capture = rise & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));

   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      bcd_d       = bcd_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      dropped_d   = dropped_q;

      case (state_q)
         ST_IDLE: begin
         end
         ST_SHIFT: begin
            bcd_d = shifted[BW+in_size-1:in_size];
            bin_d = shifted[in_size-1:0];
            cnt_d = cnt_q + CW'(1);
            if (rise) begin
               dropped_d = 1'b1;
            end
            if (cnt_q == LAST_CNT) begin
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = ST_IDLE;
            end else if (rise) begin
               dropped_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (capture) begin
         state_d = ST_SHIFT;
         bin_d   = in_data;
         bcd_d   = '0;
         cnt_d   = '0;
         busy_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         in_valid_dly_q <= 1'b0;
         bin_q          <= '0;
         bcd_q          <= '0;
         cnt_q          <= '0;
         out_valid_q    <= 1'b0;
         busy_q         <= 1'b0;
         dropped_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         in_valid_dly_q <= in_valid;
         bin_q          <= bin_d;
         bcd_q          <= bcd_d;
         cnt_q          <= cnt_d;
         out_valid_q    <= out_valid_d;
         busy_q         <= busy_d;
         dropped_q      <= dropped_d;
      end
   end

   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign bcd       = bcd_q;
   assign dropped   = dropped_q;

endmodule

// File: tb/tb_fib_bcd_converter.sv
// Directed bench for fib_bcd_converter at default widths (32-bit in, 10 digits).
module tb_fib_bcd_converter;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [39:0] bcd;
   logic        dropped;

   int unsigned total = 0;
   int unsigned bad   = 0;

   fib_bcd_converter #(.in_size(32), .digits(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bcd       (bcd),
      .dropped   (dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Capture edge, then 31 quiet cycles, then result on the 32nd edge after capture.
   task automatic convert(input string tag, input logic [31:0] data, input logic [39:0] exp_bcd);
      in_data  = data;
      in_valid = 1'b1;
      tick();
      check({tag, "_busy_at_capture"}, 64'(busy), 64'd1);
      in_valid = 1'b0;
      repeat (31) tick();
      check({tag, "_not_early"}, 64'(out_valid), 64'd0);
      tick();
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_bcd"}, 64'(bcd), 64'(exp_bcd));
   endtask

   initial begin
      logic       seen_busy;
      logic       hold_ok;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      tick();
      tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy",      64'(busy),      64'd0);
      check("rst_bcd",       64'(bcd),       64'd0);
      check("rst_dropped",   64'(dropped),   64'd0);
      rst = 1'b0;
      tick();

      // Basic conversion with immediate acceptance
      out_ready = 1'b1;
      convert("basic55", 32'd55, 40'h0000000055);
      tick();
      check("basic_single_valid", 64'(out_valid), 64'd0);
      check("basic_busy_low",     64'(busy),      64'd0);
      check("basic_bcd_retained", 64'(bcd),       64'h55);

      // Extremes
      convert("max", 32'hFFFF_FFFF, 40'h4294967295);
      tick();
      convert("zero", 32'd0, 40'h0000000000);
      tick();
      check("zero_busy_low", 64'(busy), 64'd0);

      // Level hold with a re-pulse during SHIFT
      in_data  = 32'd12345;
      in_valid = 1'b1;
      tick();
      repeat (4) tick();
      check("hold_no_drop_yet", 64'(dropped), 64'd0);
      in_valid = 1'b0;
      tick();
      in_valid = 1'b1;
      tick();
      check("hold_dropped_set", 64'(dropped), 64'd1);
      repeat (25) tick();
      check("hold_not_early", 64'(out_valid), 64'd0);
      tick();
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_bcd",   64'(bcd),       64'h12345);
      tick();
      check("hold_transfer", 64'(out_valid), 64'd0);
      seen_busy = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (busy || out_valid) seen_busy = 1'b1;
         tick();
      end
      check("hold_no_retrigger", 64'(seen_busy), 64'd0);
      check("hold_dropped_sticky", 64'(dropped), 64'd1);
      in_valid = 1'b0;
      tick();

      // Backpressure, with an ignored edge while the result waits
      do_reset();
      check("bp_dropped_cleared", 64'(dropped), 64'd0);
      out_ready = 1'b0;
      convert("bp832040", 32'd832040, 40'h0000832040);
      hold_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = (i == 4);
         tick();
         if (!out_valid || bcd !== 40'h0000832040 || !busy) hold_ok = 1'b0;
      end
      check("bp_held_stable", 64'(hold_ok), 64'd1);
      check("bp_dropped_in_done", 64'(dropped), 64'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_transfer_valid", 64'(out_valid), 64'd0);
      check("bp_transfer_busy",  64'(busy),      64'd0);

      // Same-edge transfer and capture
      do_reset();
      tick();
      out_ready = 1'b0;
      convert("se144", 32'd144, 40'h0000000144);
      tick();
      check("se_waiting", 64'(out_valid), 64'd1);
      in_data   = 32'd89;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      check("se_valid_drops", 64'(out_valid), 64'd0);
      check("se_busy_kept",   64'(busy),      64'd1);
      in_valid = 1'b0;
      repeat (31) tick();
      check("se_not_early", 64'(out_valid), 64'd0);
      tick();
      check("se_valid", 64'(out_valid), 64'd1);
      check("se_bcd",   64'(bcd),       64'h89);
      check("se_no_drop", 64'(dropped), 64'd0);
      tick();

      // Reset mid-shift with in_valid held high
      in_data  = 32'd6765;
      in_valid = 1'b1;
      tick();
      repeat (15) tick();
      check("rm_mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      tick();
      check("rm_out_valid", 64'(out_valid), 64'd0);
      check("rm_busy",      64'(busy),      64'd0);
      check("rm_bcd",       64'(bcd),       64'd0);
      rst     = 1'b0;
      in_data = 32'd75025;
      tick();
      check("rm_recapture", 64'(busy), 64'd1);
      repeat (31) tick();
      check("rm_not_early", 64'(out_valid), 64'd0);
      tick();
      check("rm_valid", 64'(out_valid), 64'd1);
      check("rm_bcd_result", 64'(bcd), 64'h75025);
      in_valid = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
